// File: rtl/vg_shifter_pkg.sv
// Shared definitions for the vector-generator operand shifter.
//   - state_t      : operation FSM states (IDLE, NORM, DONE)
//   - LD_*         : bit positions of the byte load strobes in ld[3:0]
//   - *_DEF        : default delta width and normalisation shift limit
package vg_shifter_pkg;

    localparam int COORD_W_DEF   = 13;
    localparam int MAX_SHIFT_DEF = 15;

    localparam int LD_YLO = 0;
    localparam int LD_YHI = 1;
    localparam int LD_XLO = 2;
    localparam int LD_XHI = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NORM = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/vg_axis_reg.sv
// One axis of the operand register: a COORD_W-bit signed delta plus a 3-bit
// side field (opcode on Y, intensity on X).
// Ports:
//   clk_12MHz, reset : clock and synchronous active-high reset
//   i_din            : vector data byte
//   i_ld_lo          : load delta[7:0] from i_din
//   i_ld_hi          : load delta[COORD_W-1:8] from i_din low bits, side from i_din[7:5]
//   i_clr_lo         : clear delta[7:0] (a load of the same field wins)
//   i_clr_hi         : clear delta[COORD_W-1:8] and side (a load of the same field wins)
//   i_shift          : shift delta left by one, zero fill (overrides loads)
//   o_delta, o_side  : register contents
//   o_can_shift      : top two delta bits equal, so a left shift keeps the sign
module vg_axis_reg #(
    parameter int COORD_W = 13
) (
    input  logic               clk_12MHz,
    input  logic               reset,
    input  logic [7:0]         i_din,
    input  logic               i_ld_lo,
    input  logic               i_ld_hi,
    input  logic               i_clr_lo,
    input  logic               i_clr_hi,
    input  logic               i_shift,
    output logic [COORD_W-1:0] o_delta,
    output logic [2:0]         o_side,
    output logic               o_can_shift
);

    logic [COORD_W-1:0] r_delta;
    logic [2:0]         r_side;

    always_ff @(posedge clk_12MHz) begin
        if (reset) begin
            r_delta <= '0;
            r_side  <= '0;
        end else if (i_shift) begin
            r_delta <= {r_delta[COORD_W-2:0], 1'b0};
        end else begin
            if (i_ld_lo) begin
                r_delta[7:0] <= i_din;
            end else if (i_clr_lo) begin
                r_delta[7:0] <= '0;
            end
            if (i_ld_hi) begin
                r_delta[COORD_W-1:8] <= i_din[COORD_W-9:0];
                r_side               <= i_din[7:5];
            end else if (i_clr_hi) begin
                r_delta[COORD_W-1:8] <= '0;
                r_side               <= '0;
            end
        end
    end

    assign o_delta     = r_delta;
    assign o_side      = r_side;
    assign o_can_shift = (r_delta[COORD_W-1] == r_delta[COORD_W-2]);

endmodule

// File: rtl/vg_operand_shifter.sv
// Operand register and normaliser for the vector generator. Byte strobes
// assemble the X/Y deltas, opcode and intensity; a start request either
// completes immediately or left-normalises both deltas together, counting the
// shifts for the timer/scale logic.
// Optional feature macro: VG_SHIFTER_NORM_EN (normalisation; when undefined
// start always completes without shifting and shift_cnt is 0).
// Ports:
//   clk_12MHz, reset : clock and synchronous active-high reset
//   din              : vector data byte
//   ld[3:0]          : byte strobes: [0] Y low, [1] Y high/op (+clears X, Z, Y low),
//                      [2] X low, [3] X high/Z; accepted only in IDLE
//   norm_req, start  : start an operation from IDLE, normalising if norm_req
//   busy             : high in NORM and DONE
//   done             : one-cycle pulse, registered from state==DONE
//   dvx, dvy, op, z  : assembled operands
//   shift_cnt        : left shifts applied by the last normalisation
//   state_dbg        : current FSM state
// Handshake: start is taken only on a clock edge where the FSM is IDLE; starts
// and loads while busy are dropped. done marks the first IDLE cycle after the
// operation, and outputs then hold until the next load or start.
module vg_operand_shifter
    import vg_shifter_pkg::*;
#(
    parameter int COORD_W   = COORD_W_DEF,
    parameter int MAX_SHIFT = MAX_SHIFT_DEF,
    parameter int CNT_W     = $clog2(MAX_SHIFT + 1)
) (
    input  logic               clk_12MHz,
    input  logic               reset,
    input  logic [7:0]         din,
    input  logic [3:0]         ld,
    input  logic               norm_req,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [COORD_W-1:0] dvx,
    output logic [COORD_W-1:0] dvy,
    output logic [2:0]         op,
    output logic [2:0]         z,
    output logic [CNT_W-1:0]   shift_cnt,
    output state_t             state_dbg
);

    state_t           r_state;
    state_t           w_next_state;
    logic             r_done;
    logic             w_start_acc;
    logic             w_shift;
    logic [3:0]       w_ld;
    logic             w_x_can;
    logic             w_y_can;
    logic [CNT_W-1:0] w_shift_cnt;

    // Loads are only honoured while idle.
    assign w_ld = ld & {4{r_state == ST_IDLE}};

    // ld[YHI] acts as a "new vector" marker: it clears everything except the
    // Y high byte it writes itself. Field loads in the same cycle take priority.
    vg_axis_reg #(.COORD_W(COORD_W)) u_axis_y (
        .clk_12MHz   (clk_12MHz),
        .reset       (reset),
        .i_din       (din),
        .i_ld_lo     (w_ld[LD_YLO]),
        .i_ld_hi     (w_ld[LD_YHI]),
        .i_clr_lo    (w_ld[LD_YHI]),
        .i_clr_hi    (1'b0),
        .i_shift     (w_shift),
        .o_delta     (dvy),
        .o_side      (op),
        .o_can_shift (w_y_can)
    );

    vg_axis_reg #(.COORD_W(COORD_W)) u_axis_x (
        .clk_12MHz   (clk_12MHz),
        .reset       (reset),
        .i_din       (din),
        .i_ld_lo     (w_ld[LD_XLO]),
        .i_ld_hi     (w_ld[LD_XHI]),
        .i_clr_lo    (w_ld[LD_YHI]),
        .i_clr_hi    (w_ld[LD_YHI]),
        .i_shift     (w_shift),
        .o_delta     (dvx),
        .o_side      (z),
        .o_can_shift (w_x_can)
    );

`ifdef VG_SHIFTER_NORM_EN
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_SHIFT);

    logic [CNT_W-1:0] r_shift_cnt;
    logic             w_can_shift;

    // Both deltas shift together so their ratio (the vector direction) is kept.
    assign w_can_shift = w_x_can & w_y_can & (r_shift_cnt < MAX_CNT);

    always_ff @(posedge clk_12MHz) begin
        if (reset) begin
            r_shift_cnt <= '0;
        end else if (w_start_acc) begin
            r_shift_cnt <= '0;
        end else if (w_shift) begin
            r_shift_cnt <= r_shift_cnt + 1'b1;
        end
    end

    assign w_shift_cnt = r_shift_cnt;
`else
    logic w_unused_norm;
    assign w_unused_norm = ^{norm_req, w_x_can, w_y_can};
    assign w_shift_cnt   = '0;
`endif

    always_ff @(posedge clk_12MHz) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_done  <= (r_state == ST_DONE);
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_start_acc  = 1'b0;
        w_shift      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_start_acc = 1'b1;
`ifdef VG_SHIFTER_NORM_EN
                    w_next_state = norm_req ? ST_NORM : ST_DONE;
`else
                    w_next_state = ST_DONE;
`endif
                end
            end
`ifdef VG_SHIFTER_NORM_EN
            ST_NORM: begin
                if (w_can_shift) begin
                    w_shift = 1'b1;
                end else begin
                    w_next_state = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign busy      = (r_state == ST_NORM) || (r_state == ST_DONE);
    assign done      = r_done;
    assign shift_cnt = w_shift_cnt;
    assign state_dbg = r_state;

endmodule

// File: tb/tb_vg_operand_shifter.sv
// Bench for vg_operand_shifter: directed vectors, a behavioural model that is
// checked against the outputs on every falling edge, and literal expectations
// for the hand-worked cases.
module tb_vg_operand_shifter;
    import vg_shifter_pkg::*;

    localparam int W    = 13;
    localparam int MAXS = 15;
    localparam int CW   = 4;
    localparam int MASK = (1 << W) - 1;
`ifdef VG_SHIFTER_NORM_EN
    localparam bit NORM_EN = 1'b1;
`else
    localparam bit NORM_EN = 1'b0;
`endif

    // Literal expectations for the hand-worked cases in either build.
    localparam int POS_DVY   = NORM_EN ? 'h0800 : 'h0040;
    localparam int POS_DVX   = NORM_EN ? 'h0400 : 'h0020;
    localparam int POS_CNT   = NORM_EN ? 5 : 0;
    localparam int POS_EDGES = NORM_EN ? 7 : 1;
    localparam int NEG_DVY   = NORM_EN ? 'h1000 : 'h1FFF;
    localparam int NEG_CNT   = NORM_EN ? 12 : 0;
    localparam int ZERO_CNT  = NORM_EN ? 15 : 0;
    localparam int ZERO_BUSY = NORM_EN ? 17 : 1;
    localparam int ILK_DVY   = NORM_EN ? 'h0800 : 'h0001;
    localparam int ILK_CNT   = NORM_EN ? 11 : 0;
    localparam int SL_DVY    = NORM_EN ? 'h0800 : 'h0002;
    localparam int SL_CNT    = NORM_EN ? 10 : 0;
    localparam int RST_CNT   = NORM_EN ? 3 : 0;
    localparam int RST_BUSY  = NORM_EN ? 1 : 0;

    // ---------------- clock / reset ----------------
    logic          clk;
    logic          reset;
    logic [7:0]    din;
    logic [3:0]    ld;
    logic          norm_req;
    logic          start;
    logic          busy;
    logic          done;
    logic [W-1:0]  dvx;
    logic [W-1:0]  dvy;
    logic [2:0]    op;
    logic [2:0]    z;
    logic [CW-1:0] shift_cnt;
    state_t        state_dbg;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vg_operand_shifter #(.COORD_W(W), .MAX_SHIFT(MAXS)) dut (
        .clk_12MHz (clk),
        .reset     (reset),
        .din       (din),
        .ld        (ld),
        .norm_req  (norm_req),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .dvx       (dvx),
        .dvy       (dvy),
        .op        (op),
        .z         (z),
        .shift_cnt (shift_cnt),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Current expected outputs plus the operation in flight: base deltas at
    // start, shift total n, edges since start k, busy edges remaining.
    int m_x = 0, m_y = 0, m_op = 0, m_z = 0, m_cnt = 0;
    int m_bx = 0, m_by = 0, m_n = 0, m_k = 0, m_left = 0;
    bit m_done = 1'b0;

    function automatic bit sign_ok(input int v);
        return ((v >> (W - 1)) & 1) == ((v >> (W - 2)) & 1);
    endfunction

    function automatic int norm_count(input int x, input int y);
        int n = 0;
        while (n < MAXS && sign_ok(x) && sign_ok(y)) begin
            x = (x << 1) & MASK;
            y = (y << 1) & MASK;
            n++;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_x = 0; m_y = 0; m_op = 0; m_z = 0; m_cnt = 0;
            m_left = 0; m_k = 0; m_n = 0; m_done = 1'b0;
        end else if (m_left == 0) begin
            m_done = 1'b0;
            if (ld[1]) begin
                m_x = 0;
                m_z = 0;
                m_y = m_y & 'h1F00;
            end
            if (ld[0]) m_y = (m_y & 'h1F00) | int'(din);
            if (ld[1]) begin
                m_y  = (m_y & 'hFF) | ((int'(din) & 'h1F) << 8);
                m_op = int'(din[7:5]);
            end
            if (ld[2]) m_x = (m_x & 'h1F00) | int'(din);
            if (ld[3]) begin
                m_x = (m_x & 'hFF) | ((int'(din) & 'h1F) << 8);
                m_z = int'(din[7:5]);
            end
            if (start) begin
                m_bx  = m_x;
                m_by  = m_y;
                m_k   = 0;
                m_cnt = 0;
                if (NORM_EN && norm_req) begin
                    m_n    = norm_count(m_x, m_y);
                    m_left = m_n + 2;
                end else begin
                    m_n    = 0;
                    m_left = 1;
                end
            end
        end else begin
            m_left--;
            m_k++;
            m_cnt  = (m_k < m_n) ? m_k : m_n;
            m_x    = (m_bx << m_cnt) & MASK;
            m_y    = (m_by << m_cnt) & MASK;
            m_done = (m_left == 0);
        end
    end

    always @(negedge clk) begin
        chk("m_dvx", int'(dvx), m_x);
        chk("m_dvy", int'(dvy), m_y);
        chk("m_op", int'(op), m_op);
        chk("m_z", int'(z), m_z);
        chk("m_shift_cnt", int'(shift_cnt), m_cnt);
        chk("m_busy", int'(busy), (m_left > 0) ? 1 : 0);
        chk("m_done", int'(done), int'(m_done));
    end

    // ---------------- driver tasks ----------------
    // Called at a falling edge; drives one cycle and returns at the next falling edge.
    task automatic step(input logic [3:0] l, input logic [7:0] d, input logic s, input logic nr);
        ld = l; din = d; start = s; norm_req = nr;
        @(negedge clk);
        ld = 4'h0; din = 8'h00; start = 1'b0; norm_req = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(4'h0, 8'h00, 1'b0, 1'b0);
    endtask

    // Edges after the start edge until done is seen; -1 when the budget runs out.
    task automatic run_to_done(input int budget, output int edges);
        edges = -1;
        for (int e = 1; e <= budget; e++) begin
            step(4'h0, 8'h00, 1'b0, 1'b0);
            if (done) begin
                edges = e;
                break;
            end
        end
    endtask

    // ---------------- directed sequence ----------------
    int edges;
    int bc;
    int dcount;

    initial begin
        reset = 1'b1; ld = 4'h0; din = 8'h00; start = 1'b0; norm_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_dvx", int'(dvx), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_state", int'(state_dbg), int'(ST_IDLE));
        reset = 1'b0;

        // Field load
        step(4'b0010, 8'hA5, 1'b0, 1'b0);
        step(4'b0001, 8'h12, 1'b0, 1'b0);
        chk("load_dvy", int'(dvy), 'h0512);
        chk("load_op", int'(op), 5);
        chk("load_dvx", int'(dvx), 0);

        // Several strobes in one cycle
        step(4'b1111, 8'h5A, 1'b0, 1'b0);
        chk("multi_dvx", int'(dvx), 'h1A5A);
        chk("multi_dvy", int'(dvy), 'h1A5A);
        chk("multi_z", int'(z), 2);
        step(4'b0110, 8'h33, 1'b0, 1'b0);
        chk("clrprio_dvx", int'(dvx), 'h0033);
        chk("clrprio_dvy", int'(dvy), 'h1300);
        chk("clrprio_op", int'(op), 1);

        // Positive normalisation
        step(4'b0010, 8'h00, 1'b0, 1'b0);
        step(4'b0001, 8'h40, 1'b0, 1'b0);
        step(4'b0100, 8'h20, 1'b0, 1'b0);
        step(4'b0000, 8'h00, 1'b1, 1'b1);
        run_to_done(40, edges);
        chk("pos_done_edges", edges, POS_EDGES);
        chk("pos_dvy", int'(dvy), POS_DVY);
        chk("pos_dvx", int'(dvx), POS_DVX);
        chk("pos_cnt", int'(shift_cnt), POS_CNT);
        idle(2);

        // Negative normalisation
        step(4'b0010, 8'h1F, 1'b0, 1'b0);
        step(4'b0001, 8'hFF, 1'b0, 1'b0);
        step(4'b0000, 8'h00, 1'b1, 1'b1);
        run_to_done(40, edges);
        chk("neg_dvy", int'(dvy), NEG_DVY);
        chk("neg_cnt", int'(shift_cnt), NEG_CNT);
        idle(2);

        // Zero vector saturates
        step(4'b0010, 8'h00, 1'b0, 1'b0);
        step(4'b0000, 8'h00, 1'b1, 1'b1);
        bc = busy ? 1 : 0;
        for (int i = 0; i < 40 && busy; i++) begin
            step(4'h0, 8'h00, 1'b0, 1'b0);
            if (busy) bc++;
        end
        chk("zero_busy_cycles", bc, ZERO_BUSY);
        chk("zero_done", int'(done), 1);
        chk("zero_cnt", int'(shift_cnt), ZERO_CNT);
        chk("zero_dvy", int'(dvy), 0);
        idle(2);

        // Clear and interlock
        step(4'b1000, 8'hE3, 1'b0, 1'b0);
        chk("xhi_dvx", int'(dvx), 'h0300);
        chk("xhi_z", int'(z), 7);
        step(4'b0010, 8'h00, 1'b0, 1'b0);
        chk("clr_dvx", int'(dvx), 0);
        chk("clr_z", int'(z), 0);
        step(4'b0001, 8'h01, 1'b0, 1'b0);
        step(4'b0000, 8'h00, 1'b1, 1'b1);
        step(4'b1111, 8'hFF, 1'b0, 1'b0);
        idle(30);
        chk("ilk_dvy", int'(dvy), ILK_DVY);
        chk("ilk_dvx", int'(dvx), 0);
        chk("ilk_cnt", int'(shift_cnt), ILK_CNT);
        chk("ilk_z", int'(z), 0);

        // Start and load in the same cycle
        step(4'b0010, 8'h00, 1'b0, 1'b0);
        step(4'b0001, 8'h02, 1'b1, 1'b1);
        idle(20);
        chk("same_dvy", int'(dvy), SL_DVY);
        chk("same_cnt", int'(shift_cnt), SL_CNT);

        // Reset during normalisation
        step(4'b0010, 8'h00, 1'b0, 1'b0);
        step(4'b0001, 8'h01, 1'b0, 1'b0);
        step(4'b0000, 8'h00, 1'b1, 1'b1);
        idle(3);
        chk("mid_cnt", int'(shift_cnt), RST_CNT);
        chk("mid_busy", int'(busy), RST_BUSY);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        chk("rst2_dvy", int'(dvy), 0);
        chk("rst2_cnt", int'(shift_cnt), 0);
        chk("rst2_busy", int'(busy), 0);
        chk("rst2_state", int'(state_dbg), int'(ST_IDLE));
        dcount = 0;
        for (int i = 0; i < 20; i++) begin
            step(4'h0, 8'h00, 1'b0, 1'b0);
            if (done) dcount++;
        end
        chk("rst2_no_done", dcount, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vg_operand_shifter.md
# vg_operand_shifter

Parametrised operand register and normaliser for the vector generator. Assembles X/Y deltas, opcode and intensity from four byte strobes off the vector-ROM/RAM data bus. On request, left-normalises both deltas together and reports the shift count to the timer/scale logic. Successor to the fixed 13-bit shifter: fully synchronous, width-parametrised, with a start/done handshake and a saturating shift counter.

## Interface
- COORD_W, 13, delta width including sign; legal range 9..13.
- MAX_SHIFT, 15, normalisation shift limit.
- CNT_W, $clog2(MAX_SHIFT+1), shift-count width (derived).

- clk_12MHz  in  1  vector generator clock.
- reset  in  1  synchronous, active-high.
- din  in  8  vector data byte.
- ld  in  4  byte load strobes, level-sampled each clock; [0] Y low, [1] Y high/op, [2] X low, [3] X high/Z.
- norm_req  in  1  sampled with start; 1 = normalise.
- start  in  1  begin operation (accepted only in IDLE).
- busy  out  1  high in NORM and DONE.
- done  out  1  one-cycle completion pulse.
- dvx, dvy  out  COORD_W  X/Y deltas.
- op  out  3  opcode.
- z  out  3  intensity.
- shift_cnt  out  CNT_W  number of left shifts applied.

## Operation
- Reset: all outputs 0, state IDLE.
- Loads are accepted only in IDLE and ignored while busy:
  - ld[0]: dvy[7:0] <= din.
  - ld[1]: dvy[COORD_W-1:8] <= din[COORD_W-9:0]; op <= din[7:5].
  - ld[2]: dvx[7:0] <= din.
  - ld[3]: dvx[COORD_W-1:8] <= din[COORD_W-9:0]; z <= din[7:5].
  - din bits [4:COORD_W-8] unused when COORD_W < 13.
- ld[1] also clears dvx, z and dvy[7:0].
  - Clear has lower priority than ld[0], ld[2] and ld[3] asserted in the same cycle.
  - Several strobes may be asserted in one cycle; each writes its own field.
- States and transitions:
  - IDLE + start, norm_req=1: go to NORM, shift_cnt <= 0.
  - IDLE + start, norm_req=0: go to DONE, shift_cnt <= 0.
  - NORM: a shift is allowed when dvx[W-1]==dvx[W-2], dvy[W-1]==dvy[W-2] and shift_cnt < MAX_SHIFT.
    - If allowed: shift both deltas left by one, zero fill, shift_cnt++.
    - Otherwise: go to DONE.
  - DONE: go to IDLE.
- done = registered (state==DONE).
- Zero vectors saturate at shift_cnt = MAX_SHIFT.
- start while busy is ignored.
- start and ld in the same IDLE cycle: the load is applied, and NORM evaluates the newly loaded values.
- Reset in any state returns to IDLE with all outputs cleared, taking effect at the next edge.

## Timing
- Load-to-output latency: 1 clock.
- done pulse with normalisation: n+2 edges after the start edge, where n is the number of shifts; high for exactly 1 cycle.
- done pulse without normalisation: 1 edge after the start edge.
- Next start is accepted the cycle after done.
- Outputs are stable from done until the next load or start.

## Configuration
- VG_SHIFTER_NORM_EN defined: NORM state present; behaviour as above.
- VG_SHIFTER_NORM_EN undefined:
  - NORM state removed; norm_req ignored.
  - start always goes to DONE.
  - shift_cnt tied to 0.

## Structure
- Package vg_shifter_pkg holds:
  - state enum (IDLE, NORM, DONE);
  - byte-strobe index constants (LD_YLO, LD_YHI, LD_XLO, LD_XHI);
  - COORD_W and MAX_SHIFT defaults.
- Sub-module vg_axis_reg, instantiated twice (X and Y):
  - one COORD_W delta plus 3-bit side field;
  - low/high byte load, clear and shift-left;
  - outputs the "can shift" flag (top two bits equal).

## Test plan
- Field load: ld[1] din=0xA5, then ld[0] din=0x12 -> dvy=0x0512, op=5, dvx=0, z=0.
- Positive normalisation: dvy=0x0040, dvx=0x0020, start with norm_req=1 -> dvy=0x0800, dvx=0x0400, shift_cnt=5, done pulse 7 edges after start.
- Negative normalisation: dvy=0x1FFF, dvx=0, start with norm_req=1 -> dvy=0x1000, shift_cnt=12.
- Zero vector: all zero, start with norm_req=1 -> shift_cnt=15, outputs 0; busy high 17 cycles.
- Clear and interlock:
  - ld[3] din=0xE3 -> dvx[12:8]=0x03, z=7.
  - Then ld[1] -> dvx=0, z=0.
  - ld during NORM has no effect.
- Reset during NORM at shift 3 -> next cycle IDLE, all outputs 0, no done pulse.
